// File: rtl/xor_descrambler_32.sv
// Receive-side PRBS31 descrambler: regenerates the keystream with a 31-bit
// Fibonacci LFSR and XORs it onto each accepted 32-bit word.
module xor_descrambler_32 #(
  parameter int          WIDTH        = 32,
  parameter logic [30:0] SEED_DEFAULT = 31'h7FFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [30:0]      seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      word_count,
  output logic             seeded
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends combinationally on out_ready; in_valid never feeds in_ready.
  typedef enum logic {
    ST_UNSEEDED = 1'b0,
    ST_RUN      = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [30:0]      lfsr_q, lfsr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]      word_count_q, word_count_d;

  logic [30:0]      ks_state;
  logic [WIDTH-1:0] ks_bits;
  logic             fb;
  logic             accept;
  logic             drain;

  // 32 LFSR steps unrolled; first generated bit lands in the MSB.
  always_comb begin
    ks_state = lfsr_q;
    ks_bits  = '0;
    fb       = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      fb       = ks_state[30] ^ ks_state[27];
      ks_state = {ks_state[29:0], fb};
      ks_bits  = {ks_bits[WIDTH-2:0], fb};
    end
  end

  assign in_ready = (state_q == ST_RUN) && !seed_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    word_count_d = word_count_q;

    if (seed_load) begin
      // Reseed restarts the stream and discards any pending output word.
      state_d      = ST_RUN;
      lfsr_d       = (seed == 31'd0) ? SEED_DEFAULT : seed;
      out_valid_d  = 1'b0;
      word_count_d = 16'd0;
    end else if (accept) begin
      lfsr_d       = ks_state;
      out_data_d   = in_data ^ ks_bits;
      out_valid_d  = 1'b1;
      word_count_d = word_count_q + 16'd1;
    end else if (drain) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_UNSEEDED;
      lfsr_q       <= SEED_DEFAULT;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign word_count = word_count_q;
  assign seeded     = (state_q == ST_RUN);

endmodule

// File: tb/tb_xor_descrambler_32.sv
// Bench for xor_descrambler_32: known vectors, backpressure, reseed, async
// reset and a randomised scrambler-to-descrambler round trip.
module tb_xor_descrambler_32;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [30:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] word_count;
  logic        seeded;

  int          checks;
  int          errors;
  logic [30:0] model_lfsr;
  logic [31:0] exp_q[$];

  xor_descrambler_32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_count (word_count),
    .seeded     (seeded)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {keystream[31:0], next_state[30:0]}.
  function automatic logic [62:0] prbs32(input logic [30:0] st);
    logic [30:0] s;
    logic [31:0] k;
    logic        b;
    s = st;
    k = '0;
    for (int i = 0; i < 32; i++) begin
      b = s[30] ^ s[27];
      k[31-i] = b;
      s = {s[29:0], b};
    end
    return {k, s};
  endfunction

  function automatic logic [31:0] get_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_seed(input logic [30:0] s);
    seed_load = 1'b1;
    seed      = s;
    @(posedge clk);
    @(negedge clk);
    seed_load  = 1'b0;
    model_lfsr = (s == 31'd0) ? 31'h7FFFFFFF : s;
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic put_word(input logic [31:0] d, output bit ok);
    logic [62:0] r;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      r = prbs32(model_lfsr);
      model_lfsr = r[30:0];
      exp_q.push_back(d ^ r[62:31]);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; seed_load = 1'b0; seed = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || word_count !== 16'h0 ||
        seeded !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ov=%b od=%h wc=%h sd=%b ir=%b want all zero",
               out_valid, out_data, word_count, seeded, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || seeded !== 1'b0 || word_count !== 16'h0) begin
        errors++;
        $display("FAIL unseeded_idle: ir=%b sd=%b wc=%h want 0 0 0", in_ready, seeded, word_count);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_known_vectors();
    bit ok;
    logic [31:0] e;
    logic [31:0] vin  [3] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    logic [30:0] vsd  [3] = '{31'h7FFFFFFF, 31'h7FFFFFFF, 31'h00000000};
    logic [31:0] vout [3] = '{32'h0000000E, 32'hFFFFFFF1, 32'h0000000E};
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      do_seed(vsd[t]);
      checks++;
      if (seeded !== 1'b1) begin
        errors++;
        $display("FAIL seeded_flag[%0d]: got %b want 1", t, seeded);
      end
      put_word(vin[t], ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL accept_timeout vec[%0d]", t);
      end
      e = get_exp();
      checks++;
      if (out_valid !== 1'b1 || out_data !== vout[t] || word_count !== 16'd1) begin
        errors++;
        $display("FAIL known_vec[%0d]: ov=%b od=%h wc=%0d want 1 %h 1",
                 t, out_valid, out_data, word_count, vout[t]);
      end
      checks++;
      if (out_data !== e) begin
        errors++;
        $display("FAIL model_vec[%0d]: got %h want %h", t, out_data, e);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== vout[t]) begin
        errors++;
        $display("FAIL drain_vec[%0d]: ov=%b od=%h want 0 %h", t, out_valid, out_data, vout[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] e;
    do_seed(31'h7FFFFFFF);
    out_ready = 1'b0;
    put_word(32'h0, ok);
    e = get_exp();
    checks++;
    if (!ok || out_valid !== 1'b1 || out_data !== 32'h0000000E || out_data !== e) begin
      errors++;
      $display("FAIL bp_first: ok=%b ov=%b od=%h want 1 1 0000000e", ok, out_valid, out_data);
    end
    in_valid = 1'b1;
    in_data  = 32'h0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== e || word_count !== 16'd1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ir=%b ov=%b od=%h wc=%0d want 0 1 %h 1",
                 c, in_ready, out_valid, out_data, word_count, e);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    put_word(32'h0, ok);
    e = get_exp();
    checks++;
    if (!ok || out_valid !== 1'b1 || out_data !== e || word_count !== 16'd2) begin
      errors++;
      $display("FAIL bp_second: ok=%b ov=%b od=%h wc=%0d want 1 1 %h 2",
               ok, out_valid, out_data, word_count, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [62:0] r;
    logic [31:0] d;
    logic [31:0] e;
    do_seed(31'h1234567);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      d = $urandom;
      in_data = d;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", c, in_ready);
      end
      r = prbs32(model_lfsr);
      model_lfsr = r[30:0];
      exp_q.push_back(d ^ r[62:31]);
      @(negedge clk);
      e = get_exp();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || word_count !== 16'(c + 1)) begin
        errors++;
        $display("FAIL b2b_data[%0d]: ov=%b od=%h wc=%0d want 1 %h %0d",
                 c, out_valid, out_data, word_count, e, c + 1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reseed();
    bit ok;
    logic [31:0] e;
    do_seed(31'h0ABCDEF1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      put_word($urandom, ok);
      e = get_exp();
      checks++;
      if (!ok || out_data !== e) begin
        errors++;
        $display("FAIL reseed_pre[%0d]: ok=%b od=%h want %h", c, ok, out_data, e);
      end
      if (c < 2) begin
        @(negedge clk);
      end
    end
    // out_valid is 1 here; pulse seed_load with a word offered.
    in_valid  = 1'b1;
    in_data   = 32'h0;
    seed_load = 1'b1;
    seed      = 31'h7FFFFFFF;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reseed_ready: ir=%b ov=%b want 0 1", in_ready, out_valid);
    end
    @(negedge clk);
    seed_load  = 1'b0;
    in_valid   = 1'b0;
    model_lfsr = 31'h7FFFFFFF;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL reseed_clear: ov=%b wc=%0d want 0 0", out_valid, word_count);
    end
    put_word(32'h0, ok);
    e = get_exp();
    checks++;
    if (!ok || out_data !== 32'h0000000E || out_data !== e || word_count !== 16'd1) begin
      errors++;
      $display("FAIL reseed_first: ok=%b od=%h wc=%0d want 0000000e 1", ok, out_data, word_count);
    end
  endtask

  task automatic test_reset_mid();
    do_seed(31'h55555555);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || word_count !== 16'h0 ||
        seeded !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ov=%b od=%h wc=%h sd=%b ir=%b want all zero",
               out_valid, out_data, word_count, seeded, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || word_count !== 16'h0) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: ir=%b ov=%b wc=%h want 0 0 0",
                 c, in_ready, out_valid, word_count);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_round_trip();
    localparam int N = 1000;
    logic [31:0] plain  [N];
    logic [31:0] cipher [N];
    logic [30:0] tx_lfsr;
    logic [30:0] sd;
    logic [62:0] r;
    logic [31:0] e;
    int          idx;
    int          got;
    int          cyc;
    bit          in_x;
    bit          out_x;
    sd = 31'($urandom_range(1, 32'h7FFFFFFF));
    tx_lfsr = sd;
    for (int i = 0; i < N; i++) begin
      plain[i]  = $urandom;
      r         = prbs32(tx_lfsr);
      tx_lfsr   = r[30:0];
      cipher[i] = plain[i] ^ r[62:31];
    end
    do_seed(sd);
    idx = 0;
    got = 0;
    cyc = 0;
    while ((idx < N || got < N) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (idx < N) && ($urandom_range(0, 4) != 0);
      in_data   = (idx < N) ? cipher[idx] : 32'h0;
      #1;
      out_x = out_valid && out_ready;
      in_x  = in_valid && in_ready;
      if (out_x) begin
        e = get_exp();
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL round_trip[%0d]: got %h want %h", got, out_data, e);
        end
        got++;
      end
      if (in_x) begin
        exp_q.push_back(plain[idx]);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != N || idx != N) begin
      errors++;
      $display("FAIL round_trip_timeout: sent %0d received %0d want %0d", idx, got, N);
    end
    checks++;
    if (word_count !== 16'(N)) begin
      errors++;
      $display("FAIL round_trip_count: got %0d want %0d", word_count, N);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    model_lfsr = 31'h7FFFFFFF;
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_back_to_back();
    test_reseed();
    test_reset_mid();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_descrambler_32.md
Name: xor_descrambler_32

Overview:
- Receive-side counterpart of the datapath's 32-bit XOR scrambling stage.
- Regenerates the PRBS31 keystream with an LFSR and XORs it onto each accepted 32-bit word to recover plaintext.
- Sits between the link/bus receive path and the ALU operand registers.
- Has a valid/ready input, a one-stage registered output, and explicit reseeding.

Parameters:
- WIDTH, 32, data word width; fixed, only 32 is supported.
- SEED_DEFAULT, 31'h7FFFFFFF, seed substituted when a zero seed is loaded.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- seed_load  input  1  one-cycle pulse: load seed and restart the stream.
- seed  input  31  LFSR seed, sampled when seed_load=1.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  scrambled word.
- out_valid  output  1  out_data holds a descrambled word.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  32  descrambled word.
- word_count  output  16  words accepted since the last seed, wraps.
- seeded  output  1  FSM is in RUN.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=UNSEEDED, lfsr=SEED_DEFAULT.
  - out_valid=0, out_data=0, word_count=0, seeded=0, in_ready=0.
- FSM states:
  - UNSEEDED -> RUN when seed_load=1.
  - RUN -> RUN when seed_load=1 (reseed).
  - There is no other exit from RUN except reset.
- Seed load:
  - lfsr <= (seed==0) ? SEED_DEFAULT : seed.
  - word_count <= 0 and out_valid <= 0; any pending output word is discarded.
  - in_ready=0 in that cycle, so no word is accepted.
- Handshake:
  - in_ready = (state==RUN) && !seed_load && (!out_valid || out_ready).
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Keystream, per accepted word:
  - Run 32 Fibonacci steps on the 31-bit state s.
  - Step i (i=0..31): b_i = s[30] ^ s[27]; then s = {s[29:0], b_i}.
  - K[31-i] = b_i, so the first generated bit is the MSB.
  - All 32 steps are combinational in the acceptance cycle; lfsr <= final s.
- Latency:
  - On acceptance, out_data <= in_data ^ K, out_valid <= 1, and word_count increments, all on the next edge.
  - This gives 1 cycle of latency.
  - With out_ready=1 held, throughput is 1 word/cycle.
- Hold:
  - While out_valid=1 and out_ready=0: out_data, lfsr and word_count hold.
  - in_ready is 0 during this time.
- Drain: out_valid && out_ready with no new acceptance -> out_valid <= 0; out_data holds its last value.
- Simultaneous drain and accept: out_data is replaced and out_valid stays 1.
- LFSR: advances only on input acceptance, never on idle cycles, stalls or dropped cycles.
- Lock-up: a zero state is impossible because a zero seed is replaced.
- word_count wraps 16'hFFFF -> 0.
- Reset mid-operation: all state returns to reset values immediately; a new seed_load is required.

Test Plan:
- Reset, seed_load with seed=31'h7FFFFFFF, then in_data=32'h00000000 -> one cycle later out_valid=1, out_data=32'h0000000E, word_count=1.
- Same seed, in_data=32'hFFFFFFFF as the first word -> out_data=32'hFFFFFFF1.
- seed=0 loaded -> behaves identically to seed 31'h7FFFFFFF; first word 0 yields 32'h0000000E.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after the first word.
  - Required: in_ready=0, out_data held, lfsr unchanged.
  - Then out_ready=1 with the second word 0 -> the result equals a reference model run with no stall.
- Reseed mid-stream: after 3 words, pulse seed_load with out_valid=1 -> out_valid=0, word_count=0; the next word 0 -> 32'h0000000E again.
- Assert rst_n=0 during a burst -> outputs clear asynchronously; in_ready stays 0 until seed_load.
- Round-trip: a scrambler model (same LFSR, same seed) feeds 1000 random words -> every out_data equals the original plaintext, in order.
